// File: rtl/args_arbiter.sv
// args_arbiter: round-robin arbiter for 2**N requesters.
// A grant is held until the grantee signals done or, when TMO > 0, until
// TMO grant cycles have elapsed. Every release hands priority to the channel
// after the one just served, and there is always one idle cycle before the next grant.
module args_arbiter #(
  parameter int N   = 2,
  parameter int TMO = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [(1<<N)-1:0]   req,
  input  logic                done,
  output logic                gnt_vld,
  output logic [N-1:0]        gnt_ch,
  output logic [(1<<N)-1:0]   gnt_sel,
  output logic                tmo
);

  localparam int NCH = 1 << N;
  // The counter only needs to reach TMO-1; it then saturates.
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TMO > 0) ? (TMO - 1) : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]     state;
  logic [N-1:0]   ptr;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   pick;
  logic [N-1:0]   idx;
  logic           any_req;
  logic [NCH-1:0] pick_sel;
  logic           timeout;

  // Scan requests starting at ptr and wrapping; the first set bit wins.
  always_comb begin
    pick    = ptr;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = ptr + N'(i);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  // One-hot form of the winning channel, loaded into gnt_sel on grant.
  always_comb begin
    pick_sel       = '0;
    pick_sel[pick] = 1'b1;
  end

  // The grant has run its full length when the counter reaches TMO-1.
  assign timeout = (TMO > 0) && (cnt == CNT_LAST);

  // FSM, registered outputs, rotation pointer and grant-length counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt_vld <= 1'b0;
      gnt_ch  <= '0;
      gnt_sel <= '0;
      tmo     <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo <= 1'b0;
          if (any_req) begin
            state   <= GRANT;
            gnt_vld <= 1'b1;
            gnt_ch  <= pick;
            gnt_sel <= pick_sel;
            cnt     <= '0;
          end
        end
        GRANT: begin
          if (done || timeout) begin
            state   <= IDLE;
            gnt_vld <= 1'b0;
            gnt_sel <= '0;
            ptr     <= gnt_ch + 1'b1;
            tmo     <= ~done;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          gnt_vld <= 1'b0;
          gnt_sel <= '0;
          tmo     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_args_arbiter.sv
// tb_args_arbiter: directed checks of args_arbiter with N=2, TMO=8.
// A table of per-cycle vectors covers rotation, simple grants, idle done
// and request changes during a grant; hand-written sequences cover
// timeout, done on the last grant cycle and asynchronous reset.
module tb_args_arbiter;

  localparam int N   = 2;
  localparam int TMO = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       gnt_vld;
  logic [1:0] gnt_ch;
  logic [3:0] gnt_sel;
  logic       tmo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       vld;
    logic [1:0] ch;
    logic [3:0] sel;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  args_arbiter #(.N(N), .TMO(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt_vld (gnt_vld),
    .gnt_ch  (gnt_ch),
    .gnt_sel (gnt_sel),
    .tmo     (tmo)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input logic [3:0] r, input logic d, input logic v,
                        input logic [1:0] c, input logic [3:0] s, input logic t);
    vec_t x;
    x.req = r; x.done = d; x.vld = v; x.ch = c; x.sel = s; x.tmo = t;
    vecs.push_back(x);
  endtask

  // Drive inputs, let one rising edge pass, then sample 1 ns later.
  task automatic applyStimulus(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [1:0] ec,
                             input logic [3:0] es, input logic et);
    checks += 4;
    if (gnt_vld !== ev) begin
      errors++;
      $display("[TB] FAIL %s gnt_vld: got %b expected %b", tag, gnt_vld, ev);
    end
    if (gnt_ch !== ec) begin
      errors++;
      $display("[TB] FAIL %s gnt_ch: got %0d expected %0d", tag, gnt_ch, ec);
    end
    if (gnt_sel !== es) begin
      errors++;
      $display("[TB] FAIL %s gnt_sel: got %b expected %b", tag, gnt_sel, es);
    end
    if (tmo !== et) begin
      errors++;
      $display("[TB] FAIL %s tmo: got %b expected %b", tag, tmo, et);
    end
  endtask

  initial begin
    // Fairness with all requests high: grants 0,1,2,3,0, one idle cycle between.
    addVec(4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0);
    addVec(4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    addVec(4'b1111, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0);
    addVec(4'b1111, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0);
    addVec(4'b1111, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0);
    addVec(4'b1111, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0);
    addVec(4'b1111, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0);
    addVec(4'b1111, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0);
    addVec(4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0);
    addVec(4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    // Single request on channel 2, released by done; pointer moves to 3.
    addVec(4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0);
    addVec(4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0);
    // done while idle has no effect.
    addVec(4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0);
    // Pointer at 3: req 1010 must pick channel 3, not 1.
    addVec(4'b1010, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0);
    // Grantee drops req, another channel requests: grant holds.
    addVec(4'b0000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0);
    addVec(4'b0001, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0);
    addVec(4'b0001, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0);
    // Pointer wrapped 3 -> 0.
    addVec(4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0);
    addVec(4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);

    // Reset state.
    rst  = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    #2;
    checkOutput("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    checkOutput("reset_release", 1'b0, 2'd0, 4'b0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req, vecs[i].done);
      checkOutput($sformatf("vec%0d", i), vecs[i].vld, vecs[i].ch, vecs[i].sel, vecs[i].tmo);
    end

    // Timeout: channel 0 held for 8 cycles, then tmo pulse, then regrant.
    applyStimulus(4'b0001, 1'b0);
    checkOutput("tmo_cyc1", 1'b1, 2'd0, 4'b0001, 1'b0);
    for (int k = 2; k <= TMO; k++) begin
      applyStimulus(4'b0001, 1'b0);
      checkOutput($sformatf("tmo_cyc%0d", k), 1'b1, 2'd0, 4'b0001, 1'b0);
    end
    applyStimulus(4'b0001, 1'b0);
    checkOutput("tmo_pulse", 1'b0, 2'd0, 4'b0000, 1'b1);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("tmo_regrant", 1'b1, 2'd0, 4'b0001, 1'b0);

    // done in the 8th grant cycle: done release, no tmo.
    for (int k = 2; k <= TMO; k++) begin
      applyStimulus(4'b0001, 1'b0);
      checkOutput($sformatf("late_done_cyc%0d", k), 1'b1, 2'd0, 4'b0001, 1'b0);
    end
    applyStimulus(4'b0001, 1'b1);
    checkOutput("late_done_release", 1'b0, 2'd0, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("late_done_after", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Move pointer to 3, then reset in the middle of a grant.
    applyStimulus(4'b0100, 1'b0);
    checkOutput("pre_rst_grant", 1'b1, 2'd2, 4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("pre_rst_release", 1'b0, 2'd2, 4'b0000, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("rst_grant", 1'b1, 2'd2, 4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("rst_grant_hold", 1'b1, 2'd2, 4'b0100, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    req = 4'b1010;
    @(posedge clk);
    #1;
    checkOutput("reset_held", 1'b0, 2'd0, 4'b0000, 1'b0);
    #3;
    rst = 1'b1;
    applyStimulus(4'b1010, 1'b0);
    checkOutput("post_rst_grant", 1'b1, 2'd1, 4'b0010, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("post_rst_release", 1'b0, 2'd1, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
